// File: rtl/shift_arbiter_pkg.sv
// ============================================================================
// shift_arbiter_pkg : shared encodings for the shift arbiter and its shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

package shift_arbiter_pkg;

  localparam int SHIFT_W   = 16;
  localparam int SHIFT_AMT = $clog2(SHIFT_W);

  localparam logic [1:0] SHIFT_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_SRA  = 2'b01;
  localparam logic [1:0] SHIFT_ROR  = 2'b10;
  localparam logic [1:0] SHIFT_PASS = 2'b11;

  localparam logic SHIFT_PORT_ALU = 1'b0;
  localparam logic SHIFT_PORT_MEM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/shift_arbiter_shift.sv
// ============================================================================
// shift_arbiter_shift : purely combinational barrel shifter (sll/sra/ror/pass)
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_arbiter_shift
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH = SHIFT_W
) (
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] amt,
  input  logic [1:0]               mode,
  output logic [WIDTH-1:0]         out_data
);

  logic [2*WIDTH-1:0] w_rot;

  always_comb begin
    // Rotate by shifting a doubled copy; the low half is the rotated word
    w_rot    = {in_data, in_data} >> amt;
    out_data = in_data;
    case (mode)
      SHIFT_SLL:  out_data = in_data << amt;
      SHIFT_SRA:  out_data = $signed(in_data) >>> amt;
      SHIFT_ROR:  out_data = w_rot[WIDTH-1:0];
      default:    out_data = in_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
// shift_arbiter : round-robin two-port arbiter sharing one barrel shifter,
//                 with a one-entry result register honouring backpressure
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH = SHIFT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [3:0]       req0_amt,
  input  logic [3:0]       req1_amt,
  input  logic [1:0]       req0_mode,
  input  logic [1:0]       req1_mode,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id
);

  logic             rr_ptr_q, rr_ptr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_id_q, resp_id_d;

  logic             can_accept;
  logic             grant_vld;
  logic             grant_id;
  logic [WIDTH-1:0] sh_in, sh_out;
  logic [3:0]       sh_amt;
  logic [1:0]       sh_mode;

  always_comb begin
    can_accept = !resp_valid_q || resp_ready;
    grant_vld  = 1'b0;
    grant_id   = rr_ptr_q;
    // Gating on rst_n keeps req_ready low throughout reset
    if (rst_n && can_accept) begin
      case (req_valid)
        2'b01:   begin grant_vld = 1'b1; grant_id = SHIFT_PORT_ALU; end
        2'b10:   begin grant_vld = 1'b1; grant_id = SHIFT_PORT_MEM; end
        2'b11:   begin grant_vld = 1'b1; grant_id = rr_ptr_q;       end
        default: begin grant_vld = 1'b0; grant_id = rr_ptr_q;       end
      endcase
    end
    req_ready[0] = grant_vld && (grant_id == SHIFT_PORT_ALU);
    req_ready[1] = grant_vld && (grant_id == SHIFT_PORT_MEM);
  end

  always_comb begin
    sh_in   = (grant_id == SHIFT_PORT_MEM) ? req1_data : req0_data;
    sh_amt  = (grant_id == SHIFT_PORT_MEM) ? req1_amt  : req0_amt;
    sh_mode = (grant_id == SHIFT_PORT_MEM) ? req1_mode : req0_mode;
  end

  shift_arbiter_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .in_data  (sh_in),
    .amt      (sh_amt),
    .mode     (sh_mode),
    .out_data (sh_out)
  );

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    if (grant_vld) begin
      // A grant implies the slot is free, so overwrite is always safe here
      resp_valid_d = 1'b1;
      resp_data_d  = sh_out;
      resp_id_d    = grant_id;
      rr_ptr_d     = ~grant_id;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// tb_shift_arbiter : directed self-checking bench for shift_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amt, req1_amt;
  logic [1:0]  req0_mode, req1_mode;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_id;

  int checks   = 0;
  int failures = 0;

  shift_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_data  (req0_data),
    .req1_data  (req1_data),
    .req0_amt   (req0_amt),
    .req1_amt   (req1_amt),
    .req0_mode  (req0_mode),
    .req1_mode  (req1_mode),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_port(input int p, input logic [15:0] d, input logic [3:0] a,
                          input logic [1:0] m);
    if (p == 0) begin
      req0_data = d; req0_amt = a; req0_mode = m;
    end else begin
      req1_data = d; req1_amt = a; req1_mode = m;
    end
  endtask

  // One isolated request on port p; result checked one edge later
  task automatic single(input string tag, input int p, input logic [15:0] d,
                        input logic [3:0] a, input logic [1:0] m, input logic [15:0] exp);
    set_port(p, d, a, m);
    req_valid  = (p == 0) ? 2'b01 : 2'b10;
    resp_ready = 1'b1;
    step();
    req_valid = 2'b00;
    check({tag, "_data"}, resp_data, exp);
    check({tag, "_id"}, {15'd0, resp_id}, p[15:0]);
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    set_port(0, 16'h1111, 4'd1, 2'b00);
    set_port(1, 16'h2222, 4'd1, 2'b00);
    #2;
    check("rst_valid", {15'd0, resp_valid}, 16'd0);
    check("rst_data", resp_data, 16'h0000);
    check("rst_id", {15'd0, resp_id}, 16'd0);
    check("rst_ready", {14'd0, req_ready}, 16'd0);
    step();
    req_valid = 2'b00;
    rst_n     = 1'b1;
    #1;

    // Single sra on port 0
    set_port(0, 16'h8001, 4'd1, 2'b01);
    req_valid = 2'b01;
    #1;
    check("sra_ready", {14'd0, req_ready}, 16'h0001);
    step();
    req_valid = 2'b00;
    check("sra_valid", {15'd0, resp_valid}, 16'd1);
    check("sra_data", resp_data, 16'hC000);
    check("sra_id", {15'd0, resp_id}, 16'd0);
    step();
    check("drain_valid", {15'd0, resp_valid}, 16'd0);
    check("drain_hold", resp_data, 16'hC000);

    // Contention from a fresh reset: port 0 first, then port 1
    do_reset();
    set_port(0, 16'h00F1, 4'd4, 2'b00);
    set_port(1, 16'h1234, 4'd4, 2'b10);
    req_valid = 2'b11;
    #1;
    check("cont_ready0", {14'd0, req_ready}, 16'h0001);
    step();
    check("cont_d0", resp_data, 16'h0F10);
    check("cont_id0", {15'd0, resp_id}, 16'd0);
    req_valid = 2'b10;
    #1;
    check("cont_ready1", {14'd0, req_ready}, 16'h0002);
    step();
    check("cont_d1", resp_data, 16'h4123);
    check("cont_id1", {15'd0, resp_id}, 16'd1);

    // Sustained contention: pointer is back at port 0
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("sus_valid%0d", i), {15'd0, resp_valid}, 16'd1);
      check($sformatf("sus_id%0d", i), {15'd0, resp_id}, (i % 2 == 0) ? 16'd0 : 16'd1);
      check($sformatf("sus_data%0d", i), resp_data, (i % 2 == 0) ? 16'h0F10 : 16'h4123);
    end
    req_valid = 2'b00;
    step();

    // Backpressure
    set_port(1, 16'hBEEF, 4'd5, 2'b11);
    req_valid = 2'b10;
    step();
    check("bp_first", resp_data, 16'hBEEF);
    resp_ready = 1'b0;
    set_port(0, 16'h0003, 4'd2, 2'b00);
    req_valid = 2'b01;
    #1;
    check("bp_ready_now", {14'd0, req_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_ready%0d", i), {14'd0, req_ready}, 16'd0);
      check($sformatf("bp_data%0d", i), resp_data, 16'hBEEF);
      check($sformatf("bp_id%0d", i), {15'd0, resp_id}, 16'd1);
      check($sformatf("bp_valid%0d", i), {15'd0, resp_valid}, 16'd1);
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_ready", {14'd0, req_ready}, 16'h0001);
    step();
    req_valid = 2'b00;
    check("bp_new_valid", {15'd0, resp_valid}, 16'd1);
    check("bp_new_data", resp_data, 16'h000C);
    check("bp_new_id", {15'd0, resp_id}, 16'd0);
    step();
    check("bp_empty", {15'd0, resp_valid}, 16'd0);

    // Edge shift amounts
    single("sra_amt0", 0, 16'hFFFE, 4'd0, 2'b01, 16'hFFFE);
    single("sra_amt15", 0, 16'h8000, 4'd15, 2'b01, 16'hFFFF);
    single("sll_amt15", 0, 16'h0001, 4'd15, 2'b00, 16'h8000);
    single("ror_amt15", 1, 16'h0001, 4'd15, 2'b10, 16'h0002);
    single("ror_amt0", 1, 16'hA5C3, 4'd0, 2'b10, 16'hA5C3);

    // Reset mid-operation with a buffered result and both requests pending
    set_port(0, 16'h00F1, 4'd4, 2'b00);
    set_port(1, 16'h1234, 4'd4, 2'b10);
    req_valid = 2'b11;
    step();
    resp_ready = 1'b0;
    check("mid_pre_valid", {15'd0, resp_valid}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {15'd0, resp_valid}, 16'd0);
    check("mid_rst_ready", {14'd0, req_ready}, 16'd0);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    #1;
    check("mid_post_ready", {14'd0, req_ready}, 16'h0001);
    step();
    check("mid_post_id", {15'd0, resp_id}, 16'd0);
    check("mid_post_data", resp_data, 16'h0F10);
    req_valid = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_arbiter.md
# shift_arbiter

Two-port arbiter and output buffer that shares the single 16-bit barrel shifter between the execute-stage ALU shift path (port 0) and the load/store byte-alignment path (port 1). Each port offers a request with valid/ready handshake. The arbiter grants one request per cycle with round-robin priority, drives the shifter combinationally, and captures the result with its owner tag in a one-entry output register that honours downstream backpressure.

## Interface
- `WIDTH`, 16: data width; fixed to the shifter width.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  2: per-port request valid; bit i belongs to port i.
- `req_ready`  out  2: per-port accept; a request transfers when valid and ready are both high on a clock edge.
- `req0_data`, `req1_data`  in  16 each: operand to shift.
- `req0_amt`, `req1_amt`  in  4 each: shift amount, 0–15.
- `req0_mode`, `req1_mode`  in  2 each: operation select.
  - 00 = sll
  - 01 = sra
  - 10 = ror
  - 11 = pass-through
- `resp_valid`  out  1: output register holds a result.
- `resp_ready`  in  1: downstream consumes the result when it and `resp_valid` are both high.
- `resp_data`  out  16: shifted result.
- `resp_id`  out  1: port that issued the result.

## Operation
- **State.**
  - `rr_ptr`: 1 bit, the port with priority.
  - Output register: `resp_valid`, `resp_data`, `resp_id`.
- **Slot free.** `can_accept` = `!resp_valid || resp_ready`.
- **Grant.**
  - Only when `can_accept` is high; otherwise `req_ready` = 2'b00.
  - Exactly one valid port: that port is granted.
  - Both ports valid: the port equal to `rr_ptr` is granted.
  - `req_ready[i]` is high only for the granted port. It is combinational from `req_valid`, `rr_ptr`, `resp_valid` and `resp_ready`.
  - `req_ready` never asserts for a port whose `req_valid` is low.
- **Datapath.**
  - The granted port's data, amount and mode are muxed into the shifter.
  - Shift semantics:
    - sll: zero fill.
    - sra: sign fill from bit 15.
    - ror: bits leaving bit 0 re-enter at bit 15.
    - Amount 0 returns the operand unchanged in every mode.
  - No flags are produced.
- **Capture.** On a granted transfer:
  - `resp_data` takes the shifter output.
  - `resp_id` takes the granted port.
  - `resp_valid` is set to 1.
- **Drain.** On `resp_valid && resp_ready` with no new grant, `resp_valid` clears. `resp_data` and `resp_id` hold their last values.
- **Simultaneous drain and grant.** The new result overwrites the register in the same edge and `resp_valid` stays 1. This gives full throughput of one result per cycle.
- **Priority update.** After any grant, `rr_ptr` is set to the port that was not granted. With no grant, `rr_ptr` holds.
- **Fairness.** A continuously valid port waits at most one grant before it is served.
- **Stability.** A requester must hold its fields stable while valid and not ready. The arbiter does not register request fields before grant.

## Timing
- **Latency.** A request accepted at edge N has `resp_valid` = 1 with its data after edge N, i.e. one cycle.
- **Backpressure.** `resp_ready` = 0 while `resp_valid` = 1 forces `req_ready` = 0 the same cycle. There is no loss and no overwrite.
- **Reset values.** `rst_n` low, immediate and asynchronous:
  - `resp_valid` = 0
  - `resp_data` = 16'h0000
  - `resp_id` = 0
  - `rr_ptr` = 0
  - `req_ready` = 0 while in reset.
- **Reset mid-operation.** A buffered result is discarded. No partial grant survives.
- **Leaving reset.** First grant on the first edge after `rst_n` rises, if a request is valid.

## Structure
- Shared package/header holds:
  - Mode encodings: `SHIFT_SLL` = 2'b00, `SHIFT_SRA` = 2'b01, `SHIFT_ROR` = 2'b10, `SHIFT_PASS` = 2'b11.
  - Port ids: `SHIFT_PORT_ALU` = 0, `SHIFT_PORT_MEM` = 1.
- The existing shifter (`Shift`, modes as above) is instantiated once as the sole sub-module. Its output is never registered inside it.
- Arbitration, output register and pointer live in this module.

## Test plan
- **Single sra.** Port 0 only, data 16'h8001, amt 1, mode 01 → next cycle `resp_valid` = 1, `resp_data` = 16'hC000, `resp_id` = 0.
- **Contention, sll then ror.** Both ports valid after reset:
  - Port 0: 16'h00F1, sll 4.
  - Port 1: 16'h1234, ror 4.
  - `resp_ready` = 1.
  - Expected: cycle 1 returns 16'h0F10 / id 0; cycle 2 returns 16'h4123 / id 1. `rr_ptr` alternates.
- **Sustained contention.** Both ports held valid for 8 cycles with `resp_ready` = 1 → ids alternate 0,1,0,1…; 8 results, no gaps.
- **Backpressure.** Port 1 pass-through of 16'hBEEF, then `resp_ready` = 0 for 3 cycles with port 0 valid:
  - Expected while stalled: `req_ready` = 0, and `resp_data` holds 16'hBEEF / id 1.
  - On release: same-cycle drain and grant of port 0.
- **Edge amounts.**
  - amt 0, mode 01, data 16'hFFFE → 16'hFFFE.
  - amt 15, mode 01, data 16'h8000 → 16'hFFFF.
  - amt 15, mode 00, data 16'h0001 → 16'h8000.
- **Reset mid-operation.** With `resp_valid` = 1 and both requests pending, pulse `rst_n` low between edges → `resp_valid` = 0 immediately. After release, port 0 is granted first.
